// File: rtl/processor.sv
// Minimal 8-bit register-register processor with a shared 9-bit instruction/data memory.
// Each instruction takes two cycles (FETCH then EXECUTE). Define PROC_INSTR_COUNT_EN to add the instr_count output.
module processor #(
    parameter int REG_W     = 8,
    parameter int NUM_REGS  = 16,
    parameter int MEM_DEPTH = 64,
    localparam int PC_W     = $clog2(MEM_DEPTH),
    localparam int RIDX_W   = $clog2(NUM_REGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            halted,
    output logic [PC_W-1:0] pc
`ifdef PROC_INSTR_COUNT_EN
    ,
    output logic [15:0]     instr_count
`endif
);

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_EXECUTE = 2'd1,
        S_HALT    = 2'd2
    } state_t;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LDI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_LD   = 3'b101;
    localparam logic [2:0] OP_ST   = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    state_t state, state_next;

    logic [REG_W-1:0] Reg [NUM_REGS];
    logic [8:0]       Mem [MEM_DEPTH];
    logic [PC_W-1:0]  PC;
    logic [8:0]       ir;

    logic [2:0]        op;
    logic [2:0]        rd;
    logic [2:0]        rs;
    logic [RIDX_W-1:0] rd_idx;
    logic [RIDX_W-1:0] rs_idx;
    logic [REG_W-1:0]  rd_val;
    logic [REG_W-1:0]  rs_val;
    logic [PC_W-1:0]   mem_addr;
    logic [7:0]        ld_data;

    logic              reg_we;
    logic [REG_W-1:0]  reg_wdata;
    logic              mem_we;
    logic              retire;

    assign op       = ir[8:6];
    assign rd       = ir[5:3];
    assign rs       = ir[2:0];
    assign rd_idx   = RIDX_W'(rd);
    assign rs_idx   = RIDX_W'(rs);
    assign rd_val   = Reg[rd_idx];
    assign rs_val   = Reg[rs_idx];
    assign mem_addr = rs_val[PC_W-1:0];
    assign ld_data  = Mem[mem_addr][7:0];

    assign pc     = PC;
    assign halted = (state == S_HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Operands are read from the pre-instruction register values, so rd==rs works naturally.
    always_comb begin
        state_next = state;
        reg_we     = 1'b0;
        reg_wdata  = '0;
        mem_we     = 1'b0;
        retire     = 1'b0;
        case (state)
            S_FETCH: begin
                state_next = S_EXECUTE;
            end
            S_EXECUTE: begin
                state_next = S_FETCH;
                retire     = 1'b1;
                case (op)
                    OP_NOP: ;
                    OP_LDI: begin
                        reg_we    = 1'b1;
                        reg_wdata = REG_W'(rs);
                    end
                    OP_ADD: begin
                        reg_we    = 1'b1;
                        reg_wdata = rd_val + rs_val;
                    end
                    OP_SUB: begin
                        reg_we    = 1'b1;
                        reg_wdata = rd_val - rs_val;
                    end
                    OP_AND: begin
                        reg_we    = 1'b1;
                        reg_wdata = rd_val & rs_val;
                    end
                    OP_LD: begin
                        reg_we    = 1'b1;
                        reg_wdata = REG_W'(ld_data);
                    end
                    OP_ST: begin
                        mem_we = 1'b1;
                    end
                    OP_HALT: begin
                        state_next = S_HALT;
                        retire     = 1'b0;
                    end
                    default: ;
                endcase
            end
            S_HALT: begin
                state_next = S_HALT;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            PC <= '0;
            ir <= '0;
        end else if (state == S_FETCH) begin
            ir <= Mem[PC];
            PC <= PC + PC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                Reg[i] <= '0;
            end
        end else if (reg_we) begin
            Reg[rd_idx] <= reg_wdata;
        end
    end

    // Memory has no reset; a store is only ever issued from EXECUTE, which reset always leaves.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            Mem[mem_addr] <= {1'b0, rd_val[7:0]};
        end
    end

`ifdef PROC_INSTR_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_count <= '0;
        end else if (retire) begin
            instr_count <= instr_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_processor.sv
// Self-checking bench for processor: directed programs plus random programs checked
// against an instruction-level reference model of the register file, memory and PC.
module tb_processor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       halted;
    logic [5:0] pc;
`ifdef PROC_INSTR_COUNT_EN
    logic [15:0] instr_count;
`endif

    always #5 clk = ~clk;

    processor dut (
        .clk   (clk),
        .rst_n (rst_n),
        .halted(halted),
        .pc    (pc)
`ifdef PROC_INSTR_COUNT_EN
        ,
        .instr_count(instr_count)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model state, all plain integers
    int mreg [16];
    int mmem [64];
    int mpc;
    int mhalt;
    int mcount;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d required=%0d", tag, actual, expected);
        end
    endtask

    // One whole instruction at the architectural level
    task automatic modelStep();
        int instr, op, rd, rs, a, b, addr;
        if (mhalt != 0) return;
        instr = mmem[mpc];
        mpc   = (mpc + 1) % 64;
        op    = instr / 64;
        rd    = (instr / 8) % 8;
        rs    = instr % 8;
        a     = mreg[rd];
        b     = mreg[rs];
        addr  = b % 64;
        case (op)
            1: mreg[rd] = rs;
            2: mreg[rd] = (a + b) % 256;
            3: mreg[rd] = (a - b + 256) % 256;
            4: mreg[rd] = a & b;
            5: mreg[rd] = mmem[addr] % 256;
            6: mmem[addr] = a;
            7: mhalt = 1;
            default: ;
        endcase
        if (op != 7) mcount = (mcount + 1) % 65536;
    endtask

    // Reset the core, check reset state, then backdoor-load the model image after release
    task automatic applyStimulus(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput({tag, "_rst_pc"}, 32'(pc), 32'd0);
        checkOutput({tag, "_rst_halted"}, 32'(halted), 32'd0);
        checkOutput({tag, "_rst_r3"}, 32'(dut.Reg[3]), 32'd0);
`ifdef PROC_INSTR_COUNT_EN
        checkOutput({tag, "_rst_count"}, 32'(instr_count), 32'd0);
`endif
        rst_n = 1'b1;
        for (int k = 0; k < 16; k++) dut.Reg[k] = 8'(mreg[k]);
        for (int a = 0; a < 64; a++) dut.Mem[a] = 9'(mmem[a]);
        dut.PC = 6'(mpc);
        mhalt  = 0;
        mcount = 0;
    endtask

    task automatic stepAndCheck(input string tag);
        repeat (2) @(posedge clk);
        @(negedge clk);
        modelStep();
        checkOutput({tag, "_pc"}, 32'(pc), 32'(mpc));
        checkOutput({tag, "_halted"}, 32'(halted), 32'(mhalt));
        for (int k = 0; k < 16; k++)
            checkOutput($sformatf("%s_r%0d", tag, k), 32'(dut.Reg[k]), 32'(mreg[k]));
`ifdef PROC_INSTR_COUNT_EN
        checkOutput({tag, "_count"}, 32'(instr_count), 32'(mcount));
`endif
    endtask

    task automatic checkMemory(input string tag);
        for (int a = 0; a < 64; a++)
            checkOutput($sformatf("%s_mem%0d", tag, a), 32'(dut.Mem[a]), 32'(mmem[a]));
    endtask

    task automatic clearModel();
        for (int k = 0; k < 16; k++) mreg[k] = k;
        for (int a = 0; a < 64; a++) mmem[a] = 0;
        mpc = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        mhalt = 0;
        mcount = 0;

        // Program 1: NOP; ADD R3,R4; SUB R6,R5; HALT
        clearModel();
        mmem[1] = 9'b010_011_100;
        mmem[2] = 9'b011_110_101;
        mmem[3] = 9'b111_000_000;
        applyStimulus("p1");
        for (int i = 0; i < 4; i++) stepAndCheck("p1");
        checkOutput("p1_r3", 32'(dut.Reg[3]), 32'd7);
        checkOutput("p1_r6", 32'(dut.Reg[6]), 32'd1);
        checkOutput("p1_halted", 32'(halted), 32'd1);
        checkOutput("p1_pc", 32'(pc), 32'd4);
`ifdef PROC_INSTR_COUNT_EN
        checkOutput("p1_count", 32'(instr_count), 32'd3);
`endif
        repeat (10) @(posedge clk);
        @(negedge clk);
        checkOutput("p1_frozen_pc", 32'(pc), 32'd4);
        checkOutput("p1_frozen_halted", 32'(halted), 32'd1);
`ifdef PROC_INSTR_COUNT_EN
        checkOutput("p1_frozen_count", 32'(instr_count), 32'd3);
`endif

        // Program 2: SUB R1,R2 wraps, ADD R2,R2 uses the pre-instruction value
        clearModel();
        mreg[1] = 0;
        mreg[2] = 1;
        mmem[0] = 9'b011_001_010;
        mmem[1] = 9'b010_010_010;
        mmem[2] = 9'b111_000_000;
        applyStimulus("p2");
        for (int i = 0; i < 3; i++) stepAndCheck("p2");
        checkOutput("p2_r1", 32'(dut.Reg[1]), 32'd255);
        checkOutput("p2_r2", 32'(dut.Reg[2]), 32'd2);

        // Program 3: LDI R5,6; ST [R5],R7; LD R4,[R5]
        clearModel();
        mreg[7] = 200;
        mmem[0] = 9'b001_101_110;
        mmem[1] = 9'b110_111_101;
        mmem[2] = 9'b101_100_101;
        mmem[3] = 9'b111_000_000;
        applyStimulus("p3");
        for (int i = 0; i < 4; i++) stepAndCheck("p3");
        checkOutput("p3_mem6", 32'(dut.Mem[6]), 32'd200);
        checkOutput("p3_r4", 32'(dut.Reg[4]), 32'd200);
        checkMemory("p3");

        // Reset asserted during the EXECUTE of an ADD
        clearModel();
        mmem[0] = 9'b010_011_100;
        applyStimulus("p4");
        @(posedge clk);
        @(negedge clk);
        checkOutput("p4_fetched_pc", 32'(pc), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("p4_async_pc", 32'(pc), 32'd0);
        checkOutput("p4_async_halted", 32'(halted), 32'd0);
        checkOutput("p4_async_r3", 32'(dut.Reg[3]), 32'd0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("p4_held_r3", 32'(dut.Reg[3]), 32'd0);
        checkOutput("p4_held_pc", 32'(pc), 32'd0);
        checkOutput("p4_mem0", 32'(dut.Mem[0]), 32'(9'b010_011_100));

        // PC wrap from 63 to 0, then HALT
        clearModel();
        mpc      = 63;
        mmem[0]  = 9'b111_000_000;
        applyStimulus("p5");
        stepAndCheck("p5");
        checkOutput("p5_wrap_pc", 32'(pc), 32'd0);
        stepAndCheck("p5");
        checkOutput("p5_halted", 32'(halted), 32'd1);
        checkOutput("p5_pc", 32'(pc), 32'd1);

        // Random programs, HALT made rare so most runs go the full length
        for (int round = 0; round < 20; round++) begin
            for (int k = 0; k < 16; k++) mreg[k] = int'($urandom_range(0, 255));
            for (int a = 0; a < 64; a++) begin
                int op;
                op = int'($urandom_range(0, 7));
                if (op == 7 && $urandom_range(0, 3) != 0) op = 0;
                mmem[a] = op * 64 + int'($urandom_range(0, 63));
            end
            mpc = int'($urandom_range(0, 63));
            applyStimulus($sformatf("rnd%0d", round));
            for (int i = 0; i < 30; i++) stepAndCheck($sformatf("rnd%0d", round));
            checkMemory($sformatf("rnd%0d", round));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
